// File: rtl/usb_crc_pkg.sv
// Shared definitions for the serial CRC16 scheduler.
//   crc_sched_state_t : scheduler FSM states
//   CRC16_SEED        : value the engine re-seeds to after an acknowledge
//   CRC16_DATA_BITS   : fixed number of payload bits the engine consumes per job
package usb_crc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        WAIT,
        RESP
    } crc_sched_state_t;

    localparam logic [15:0] CRC16_SEED      = 16'hFFFF;
    localparam int unsigned CRC16_DATA_BITS = 64;

endpackage

// File: rtl/crc_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req     : per-requester request bits
//   ptr     : index of the requester that currently has highest priority
//   gnt     : one-hot grant (all zero when no request)
//   gnt_idx : binary index of the granted requester (0 when no request)
module crc_rr_arbiter #(
    parameter int unsigned N_REQ = 2,
    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    logic        found;
    int unsigned cand;

    // Scan requesters starting at ptr, wrapping; first active one wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = 0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand = 32'(ptr) + i;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                gnt_idx   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/crc16_share_ctrl.sv
// Serial CRC16 scheduler: shares one bit-serial CRC16 engine between N_REQ requesters.
// A round-robin winner's payload is latched, streamed LSB-first to the engine, and the
// engine's complemented remainder is returned to the owner with a one-cycle resp_valid.
//   clk, rst     : clock, synchronous active-high reset
//   req          : per-requester level request, held until its resp_valid
//   req_data     : payload of requester i in [i*DATA_BITS +: DATA_BITS]
//   resp_valid   : one-hot 1-cycle pulse naming the owner of resp_crc
//   resp_crc     : CRC result, non-zero only while resp_valid is set
//   busy         : a job is in flight
//   eng_start    : first-bit marker to the engine
//   eng_bit      : serial payload bit to the engine
//   eng_rec      : acknowledge to the engine (re-seed)
//   eng_done     : engine result is final
//   eng_val      : engine complemented remainder
module crc16_share_ctrl
    import usb_crc_pkg::*;
#(
    parameter int unsigned N_REQ     = 2,
    parameter int unsigned DATA_BITS = CRC16_DATA_BITS
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_REQ-1:0]             req,
    input  logic [N_REQ*DATA_BITS-1:0]   req_data,
    output logic [N_REQ-1:0]             resp_valid,
    output logic [15:0]                  resp_crc,
    output logic                         busy,
    output logic                         eng_start,
    output logic                         eng_bit,
    output logic                         eng_rec,
    input  logic                         eng_done,
    input  logic [15:0]                  eng_val
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(DATA_BITS) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_BITS - 1);

    crc_sched_state_t       state_q, state_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       owner_q, owner_d;
    logic [N_REQ-1:0]       owner_oh_q, owner_oh_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [15:0]            crc_q, crc_d;

    logic [N_REQ-1:0]       gnt;
    logic [IDX_W-1:0]       gnt_idx;

    crc_rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arb (
        .req     (req),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        owner_d    = owner_q;
        owner_oh_d = owner_oh_q;
        ptr_d      = ptr_q;
        crc_d      = crc_q;

        resp_valid = '0;
        resp_crc   = '0;
        eng_start  = 1'b0;
        eng_bit    = 1'b0;
        eng_rec    = 1'b0;
        busy       = (state_q != IDLE);

        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    owner_d    = gnt_idx;
                    owner_oh_d = gnt;
                    shreg_d    = req_data[gnt_idx * DATA_BITS +: DATA_BITS];
                    cnt_d      = '0;
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                eng_start = 1'b1;
                eng_bit   = shreg_q[0];
                shreg_d   = shreg_q >> 1;
                cnt_d     = CNT_W'(1);
                state_d   = SHIFT;
            end
            SHIFT: begin
                // cnt_q is the index of the bit on eng_bit this cycle.
                eng_bit = shreg_q[0];
                shreg_d = shreg_q >> 1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // eng_done is only honoured here; an early done is a protocol error and ignored.
                if (eng_done) begin
                    crc_d   = eng_val;
                    state_d = RESP;
                end
            end
            RESP: begin
                resp_valid = owner_oh_q;
                resp_crc   = crc_q;
                eng_rec    = 1'b1;
                ptr_d      = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            cnt_q      <= '0;
            owner_q    <= '0;
            owner_oh_q <= '0;
            ptr_q      <= '0;
            crc_q      <= '0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            cnt_q      <= cnt_d;
            owner_q    <= owner_d;
            owner_oh_q <= owner_oh_d;
            ptr_q      <= ptr_d;
            crc_q      <= crc_d;
        end
    end

endmodule

// File: tb/tb_crc16_share_ctrl.sv
// Bench for crc16_share_ctrl: behavioural serial CRC16 engine, reference CRC model,
// scoreboard of expected responses, table-driven single jobs plus multi-cycle sequences.
module tb_crc16_share_ctrl;

    localparam int unsigned N_REQ = 2;
    localparam int unsigned DBITS = 64;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [N_REQ-1:0]         req;
    logic [N_REQ*DBITS-1:0]   req_data;
    logic [N_REQ-1:0]         resp_valid;
    logic [15:0]              resp_crc;
    logic                     busy;
    logic                     eng_start;
    logic                     eng_bit;
    logic                     eng_rec;
    logic                     eng_done;
    logic [15:0]              eng_val;

    crc16_share_ctrl #(
        .N_REQ     (N_REQ),
        .DATA_BITS (DBITS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_data   (req_data),
        .resp_valid (resp_valid),
        .resp_crc   (resp_crc),
        .busy       (busy),
        .eng_start  (eng_start),
        .eng_bit    (eng_bit),
        .eng_rec    (eng_rec),
        .eng_done   (eng_done),
        .eng_val    (eng_val)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: MSB-first CRC16 (poly 0x8005), bit-reversed and complemented at the end.
    function automatic logic [15:0] ref_crc(input logic [63:0] d);
        logic [15:0] r;
        logic [15:0] o;
        r = 16'hFFFF;
        for (int k = 0; k < 64; k++) begin
            if (r[15] ^ d[k]) r = (r << 1) ^ 16'h8005;
            else              r = r << 1;
        end
        for (int k = 0; k < 16; k++) o[k] = r[15-k];
        return ~o;
    endfunction

    // Engine step: reflected LSB-first CRC16 (poly 0xA001).
    function automatic logic [15:0] eng_step(input logic [15:0] c, input logic b);
        if (c[0] ^ b) return (c >> 1) ^ 16'hA001;
        return c >> 1;
    endfunction

    // ---------------- behavioural engine ----------------
    logic [15:0] eng_crc;
    int unsigned eng_cnt;
    logic        eng_active;
    logic        eng_done_r;
    int unsigned eng_hold;
    int unsigned done_delay;
    logic        err_done;

    logic [15:0] eng_src;
    logic [15:0] eng_next;
    int unsigned cnt_nxt;
    assign eng_src  = eng_start ? 16'hFFFF : eng_crc;
    assign eng_next = eng_step(eng_src, eng_bit);
    assign cnt_nxt  = eng_start ? 1 : eng_cnt + 1;
    assign eng_done = eng_done_r | err_done;
    assign eng_val  = ~eng_crc;

    always @(posedge clk) begin
        if (rst || eng_rec) begin
            eng_crc    <= 16'hFFFF;
            eng_cnt    <= 0;
            eng_active <= 1'b0;
            eng_done_r <= 1'b0;
            eng_hold   <= 0;
        end else if (eng_start || eng_active) begin
            eng_crc <= eng_next;
            eng_cnt <= cnt_nxt;
            if (cnt_nxt == DBITS) begin
                eng_active <= 1'b0;
                if (done_delay == 0) eng_done_r <= 1'b1;
                else                 eng_hold   <= done_delay;
            end else begin
                eng_active <= 1'b1;
            end
        end else if (eng_hold != 0) begin
            eng_hold <= eng_hold - 1;
            if (eng_hold == 1) eng_done_r <= 1'b1;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        int unsigned who;
        logic [15:0] crc;
    } sb_t;
    sb_t sb[$];

    task automatic sb_push(input int unsigned who, input logic [63:0] data);
        sb_t e;
        e.who = who;
        e.crc = ref_crc(data);
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        sb_t              e;
        logic [N_REQ-1:0] oh;
        if (!rst && resp_valid != '0) begin
            if (sb.size() == 0) begin
                check("resp_unexpected", 64'(resp_valid), 64'd0);
            end else begin
                e  = sb.pop_front();
                oh = '0;
                oh[e.who] = 1'b1;
                check("resp_owner", 64'(resp_valid), 64'(oh));
                check("resp_crc", 64'(resp_crc), 64'(e.crc));
                check("eng_rec_with_resp", 64'(eng_rec), 64'd1);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic wait_for(input bit want_resp, input int unsigned limit, input string name,
                            output int unsigned t);
        bit hit;
        hit = 1'b0;
        t   = 0;
        while (!hit && t < limit) begin
            @(negedge clk);
            t++;
            hit = want_resp ? (resp_valid != '0) : eng_start;
        end
        if (!hit) check({name, "_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic run_job(input int unsigned who, input logic [63:0] data,
                           input int unsigned delay, input int unsigned exp_lat,
                           input string name);
        logic [63:0] bits;
        int unsigned nb, t, t_start, t_done, t_resp, nstart;
        bit          got, busy_ok, seen_done;
        bits = '0; nb = 0; t = 0; t_start = 0; t_done = 0; t_resp = 0; nstart = 0;
        got = 1'b0; busy_ok = 1'b1; seen_done = 1'b0;
        done_delay = delay;
        req_data[who*DBITS +: DBITS] = data;
        req[who] = 1'b1;
        sb_push(who, data);
        while (!got && t < 300) begin
            @(negedge clk);
            t++;
            if (eng_start) begin
                nstart++;
                t_start = t;
            end
            if (nstart > 0 && nb < DBITS) begin
                bits[nb] = eng_bit;
                nb++;
            end
            if (eng_done && !seen_done) begin
                seen_done = 1'b1;
                t_done    = t;
            end
            if (resp_valid != '0) begin
                got      = 1'b1;
                t_resp   = t;
                req[who] = 1'b0;
            end else if (!busy) begin
                busy_ok = 1'b0;
            end
        end
        if (!got) begin
            check({name, "_timeout"}, 64'd0, 64'd1);
            req[who] = 1'b0;
        end else begin
            check({name, "_start_offset"}, 64'(t_start), 64'd1);
            check({name, "_start_count"}, 64'(nstart), 64'd1);
            check({name, "_bitstream"}, bits, data);
            check({name, "_latency"}, 64'(t_resp), 64'(exp_lat));
            check({name, "_busy_held"}, 64'(busy_ok), 64'd1);
            check({name, "_done_to_resp"}, 64'(t_resp - t_done), 64'd1);
        end
        @(negedge clk);
        check({name, "_idle_after"}, 64'({busy, resp_valid, eng_rec}), 64'd0);
    endtask

    // ---------------- table ----------------
    typedef struct {
        int unsigned who;
        logic [63:0] data;
        int unsigned delay;
        int unsigned exp_lat;
    } vec_t;
    vec_t vecs[5];

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned t, nresp;
        logic [63:0] da, db;

        vecs[0] = '{who: 0, data: 64'h0,                     delay: 0,  exp_lat: 66};
        vecs[1] = '{who: 0, data: 64'h0000_0000_0000_0001,   delay: 0,  exp_lat: 66};
        vecs[2] = '{who: 1, data: 64'hDEAD_BEEF_CAFE_F00D,   delay: 3,  exp_lat: 69};
        vecs[3] = '{who: 0, data: 64'hFFFF_FFFF_FFFF_FFFF,   delay: 0,  exp_lat: 66};
        vecs[4] = '{who: 1, data: 64'h0123_4567_89AB_CDEF,   delay: 10, exp_lat: 76};

        rst = 1'b1; req = '0; req_data = '0; done_delay = 0; err_done = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_outputs", 64'({resp_valid, resp_crc, eng_start, eng_bit, eng_rec}), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_no_req", 64'({busy, eng_start}), 64'd0);

        for (int i = 0; i < 5; i++) begin
            run_job(vecs[i].who, vecs[i].data, vecs[i].delay, vecs[i].exp_lat,
                    $sformatf("vec%0d", i));
        end

        // Both requesting continuously: grants alternate 0,1,0,1.
        done_delay = 0;
        da = 64'hA5A5_0000_1111_2222;
        db = 64'h5A5A_3333_4444_5555;
        req_data = {db, da};
        sb_push(0, da); sb_push(1, db); sb_push(0, da); sb_push(1, db);
        req   = 2'b11;
        nresp = 0;
        t     = 0;
        while (nresp < 4 && t < 400) begin
            @(negedge clk);
            t++;
            if (resp_valid != '0) begin
                nresp++;
                if (nresp == 4) req = 2'b00;
            end
        end
        req = 2'b00;
        check("rr_resp_count", 64'(nresp), 64'd4);
        @(negedge clk);

        // Late request and mid-job data change, plus an early eng_done glitch in SHIFT.
        da = 64'h1357_9BDF_0246_8ACE;
        db = 64'hFEDC_BA98_7654_3210;
        req_data[63:0] = da;
        sb_push(0, da); sb_push(1, db);
        req[0] = 1'b1;
        wait_for(1'b0, 10, "late_start0", t);
        repeat (20) @(negedge clk);
        req[1] = 1'b1;
        req_data[127:64] = db;
        req_data[63:0]   = ~da;
        err_done = 1'b1;
        repeat (3) @(negedge clk);
        err_done = 1'b0;
        check("early_done_ignored", 64'(busy && resp_valid == '0), 64'd1);
        wait_for(1'b1, 100, "late_resp0", t);
        req[0] = 1'b0;
        wait_for(1'b0, 10, "late_start1", t);
        check("late_grant_gap", 64'(t), 64'd2);
        wait_for(1'b1, 100, "late_resp1", t);
        check("late_resp1_latency", 64'(t), 64'd65);
        req[1] = 1'b0;
        @(negedge clk);

        // Reset in the middle of SHIFT (cnt = 20).
        req_data[63:0] = 64'hCCCC_3333_CCCC_3333;
        req[0] = 1'b1;
        wait_for(1'b0, 10, "rst_start", t);
        repeat (20) @(negedge clk);
        check("rst_pre_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_outputs", 64'({eng_start, eng_rec, resp_valid, eng_bit}), 64'd0);
        rst = 1'b0;
        run_job(1, 64'h0F0F_F0F0_1234_ABCD, 0, 66, "post_rst");

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
